// File: rtl/debounce_bank.sv
// Multi-channel button/switch debouncer: synchroniser, symmetric stability filter,
// polarity correction, press/release pulses and optional auto-repeat per channel.
module debounce_bank #(
    parameter int              N            = 8,
    parameter int              CNT_W        = 20,
    parameter int              STABLE_CNT   = 100000,
    parameter int              SYNC_STAGES  = 2,
    parameter logic [N-1:0]    ACTIVE_LOW   = '0,
    parameter int              RPT_W        = 24,
    parameter int              REPEAT_DELAY = 0,
    parameter int              REPEAT_RATE  = 5000000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] in,
    output logic [N-1:0] level,
    output logic [N-1:0] rise,
    output logic [N-1:0] fall,
    output logic [N-1:0] rpt,
    output logic         any
);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(STABLE_CNT - 1);
    localparam logic [RPT_W-1:0] RPT_FIRST = RPT_W'(REPEAT_DELAY);
    localparam logic [RPT_W-1:0] RPT_NEXT  = RPT_W'(REPEAT_RATE);

    genvar i;
    generate
        for (i = 0; i < N; i++) begin : g_ch
            logic [SYNC_STAGES-1:0] sync_q;
            logic                   s;
            logic                   flip;
            logic [CNT_W-1:0]       cnt_q;
            logic                   lvl_q;
            logic                   rise_q;
            logic                   fall_q;
            logic [RPT_W-1:0]       rcnt_q;
            logic                   rep_q;
            logic                   rpt_q;
            logic [RPT_W-1:0]       target;

            assign s    = sync_q[SYNC_STAGES-1] ^ ACTIVE_LOW[i];
            assign flip = (s != lvl_q) && (cnt_q == CNT_LAST);

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sync_q <= '0;
                end else begin
                    sync_q <= {sync_q[SYNC_STAGES-2:0], in[i]};
                end
            end

            // Both directions need STABLE_CNT consecutive disagreeing samples;
            // any agreeing sample restarts the count.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_q  <= '0;
                    lvl_q  <= 1'b0;
                    rise_q <= 1'b0;
                    fall_q <= 1'b0;
                end else if (s == lvl_q) begin
                    cnt_q  <= '0;
                    rise_q <= 1'b0;
                    fall_q <= 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_q  <= '0;
                    lvl_q  <= s;
                    rise_q <= s;
                    fall_q <= ~s;
                end else begin
                    cnt_q  <= cnt_q + CNT_W'(1);
                    rise_q <= 1'b0;
                    fall_q <= 1'b0;
                end
            end

            // Phase counter: first period is REPEAT_DELAY, later ones REPEAT_RATE.
            // It wraps to zero on every repeat, so a long hold never overflows.
            assign target = rep_q ? RPT_NEXT : RPT_FIRST;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rcnt_q <= '0;
                    rep_q  <= 1'b0;
                    rpt_q  <= 1'b0;
                end else if ((REPEAT_DELAY == 0) || !lvl_q || flip) begin
                    rcnt_q <= '0;
                    rep_q  <= 1'b0;
                    rpt_q  <= 1'b0;
                end else if (rcnt_q + RPT_W'(1) == target) begin
                    rcnt_q <= '0;
                    rep_q  <= 1'b1;
                    rpt_q  <= 1'b1;
                end else begin
                    rcnt_q <= rcnt_q + RPT_W'(1);
                    rpt_q  <= 1'b0;
                end
            end

            assign level[i] = lvl_q;
            assign rise[i]  = rise_q;
            assign fall[i]  = fall_q;
            assign rpt[i]   = rpt_q;
        end
    endgenerate

    assign any = |level;

endmodule

// File: tb/tb_debounce_bank.sv
// Randomised and directed bench for debounce_bank against a sliding-window
// reference model of the debounce and auto-repeat rules.
module tb_debounce_bank;
    localparam int N  = 4;
    localparam int ST = 4;
    localparam int SY = 2;
    localparam int RD = 10;
    localparam int RR = 3;
    localparam logic [N-1:0] AL = 4'b0100;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] in_r;
    logic [N-1:0] level, rise, fall, rpt;
    logic         any;

    always #5 clk = ~clk;

    debounce_bank #(
        .N(N), .CNT_W(4), .STABLE_CNT(ST), .SYNC_STAGES(SY), .ACTIVE_LOW(AL),
        .RPT_W(8), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
    ) dut (
        .clk(clk), .rst(rst), .in(in_r), .level(level), .rise(rise),
        .fall(fall), .rpt(rpt), .any(any)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: s at an edge is the pin sampled SY edges earlier (zero
    // after reset); level flips once the last ST values of s all disagree with it.
    bit [SY-1:0]  m_pipe [N];
    bit [ST-1:0]  m_win  [N];
    int           m_wn   [N];
    bit           m_lvl  [N];
    int           m_rise_at [N];
    int           m_edge;
    logic [N-1:0] e_lvl, e_rise, e_fall, e_rpt;

    task automatic model_reset();
        for (int c = 0; c < N; c++) begin
            m_pipe[c] = '0; m_win[c] = '0; m_wn[c] = 0; m_lvl[c] = 0; m_rise_at[c] = 0;
        end
        m_edge = 0;
        e_lvl = '0; e_rise = '0; e_fall = '0; e_rpt = '0;
    endtask

    task automatic model_step();
        bit s;
        int d;
        m_edge++;
        for (int c = 0; c < N; c++) begin
            s = m_pipe[c][SY-1] ^ AL[c];
            m_pipe[c] = {m_pipe[c][SY-2:0], in_r[c]};
            m_win[c] = {m_win[c][ST-2:0], s};
            if (m_wn[c] < ST) m_wn[c]++;
            e_rise[c] = 1'b0; e_fall[c] = 1'b0; e_rpt[c] = 1'b0;
            if (m_wn[c] == ST && m_win[c] == {ST{~m_lvl[c]}}) begin
                m_lvl[c] = ~m_lvl[c];
                m_wn[c] = 0;
                if (m_lvl[c]) begin
                    e_rise[c] = 1'b1;
                    m_rise_at[c] = m_edge;
                end else begin
                    e_fall[c] = 1'b1;
                end
            end else if (m_lvl[c]) begin
                d = m_edge - m_rise_at[c];
                if (d >= RD && ((d - RD) % RR) == 0) e_rpt[c] = 1'b1;
            end
            e_lvl[c] = m_lvl[c];
        end
    endtask

    task automatic check_all();
        check("level", 32'(level), 32'(e_lvl));
        check("rise",  32'(rise),  32'(e_rise));
        check("fall",  32'(fall),  32'(e_fall));
        check("rpt",   32'(rpt),   32'(e_rpt));
        check("any",   32'(any),   32'(|e_lvl));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_level"}, 32'(level), 0);
        check({tag, "_rise"},  32'(rise),  0);
        check({tag, "_fall"},  32'(fall),  0);
        check({tag, "_rpt"},   32'(rpt),   0);
        check({tag, "_any"},   32'(any),   0);
    endtask

    task automatic cycle(input logic [N-1:0] pins);
        in_r = pins;
        @(posedge clk);
        if (rst) model_reset(); else model_step();
        @(negedge clk);
        check_all();
    endtask

    // kind 0: wait for rise[ch], kind 1: wait for fall[ch]; lat=-1 on timeout
    task automatic run_until(input logic [N-1:0] pins, input int ch, input int kind, output int lat);
        int k;
        k = 0;
        lat = -1;
        while (lat < 0 && k < 30) begin
            k++;
            cycle(pins);
            if ((kind == 0 && rise[ch]) || (kind == 1 && fall[ch])) lat = k;
        end
    endtask

    logic [N-1:0] pins;
    int           lat, cnt, first, last;
    int           hold [N];
    logic [7:0]   bounce;

    initial begin
        rst = 1'b1;
        in_r = 4'b0100;
        model_reset();
        repeat (2) @(negedge clk);
        check_zero("reset");

        // clean press on ch0 while ch2 (active low) sits deasserted at pin=1
        rst = 1'b0;
        pins = 4'b0101;
        run_until(pins, 0, 0, lat);
        check("press_lat", lat, 6);

        // bounce on ch1: 1,1,1,0 then steady 1
        bounce = 8'b0111;
        for (int k = 0; k < 4; k++) begin
            pins[1] = bounce[k];
            cycle(pins);
        end
        pins[1] = 1'b1;
        run_until(pins, 1, 0, lat);
        check("bounce_lat", lat, 6);

        // 3-cycle pulse on ch3 alone must not register
        cnt = 0;
        for (int k = 0; k < 11; k++) begin
            pins[3] = (k < 3);
            cycle(pins);
            cnt += int'(rise[3]);
        end
        check("short_pulse_rise", cnt, 0);

        // release filtering on ch0, then a 2-cycle low glitch
        pins[0] = 1'b0;
        run_until(pins, 0, 1, lat);
        check("release_lat", lat, 6);
        pins[0] = 1'b1;
        run_until(pins, 0, 0, lat);
        check("repress_lat", lat, 6);
        cnt = 0;
        for (int k = 0; k < 12; k++) begin
            pins[0] = !(k < 2);
            cycle(pins);
            cnt += int'(fall[0]);
        end
        check("glitch_fall", cnt, 0);

        // active-low ch2 asserted by driving the pin low
        pins[2] = 1'b0;
        run_until(pins, 2, 0, lat);
        check("active_low_lat", lat, 6);

        // auto-repeat on ch3
        pins[3] = 1'b1;
        run_until(pins, 3, 0, lat);
        check("rpt_press_lat", lat, 6);
        cnt = 0; first = -1; last = -1;
        for (int k = 1; k <= 17; k++) begin
            cycle(pins);
            if (rpt[3]) begin
                cnt++;
                if (first < 0) first = k;
                last = k;
            end
        end
        check("rpt_count", cnt, 3);
        check("rpt_first", first, 10);
        check("rpt_last", last, 16);
        pins[3] = 1'b0;
        run_until(pins, 3, 1, lat);
        check("rpt_release_lat", lat, 6);
        cnt = 0;
        for (int k = 0; k < 12; k++) begin
            cycle(pins);
            cnt += int'(rpt[3]);
        end
        check("rpt_after_release", cnt, 0);

        // async reset while ch0 is mid-count toward a press
        pins[0] = 1'b0;
        run_until(pins, 0, 1, lat);
        check("pre_reset_release", lat, 6);
        pins[0] = 1'b1;
        repeat (4) cycle(pins);
        rst = 1'b1;
        #1;
        check_zero("async_reset");
        model_reset();
        repeat (2) cycle(pins);
        rst = 1'b0;
        run_until(pins, 0, 0, lat);
        check("post_reset_lat", lat, 6);

        // randomised bouncing on all channels
        for (int c = 0; c < N; c++) hold[c] = 0;
        for (int k = 0; k < 600; k++) begin
            for (int c = 0; c < N; c++) begin
                if (hold[c] == 0) begin
                    pins[c] = 1'($urandom_range(0, 1));
                    hold[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(6, 20))
                                                         : int'($urandom_range(1, 4));
                end
                hold[c]--;
            end
            cycle(pins);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

endmodule
